led_serial_sched: RTL and testbench

- Two-requester job scheduler that shares one bit-serial LED core (`led_serial`: 128-bit key, 64-bit block, start/done) between two clients.
- Arbitrates requests round-robin, latches key/data, sequences the core's start pulse, and detects completion.
- Bounds each job with a timeout that resets a hung core and returns an error response.
- Sits between the system bus adapters and the `led_serial` instance.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_rr_arb2.sv | 16 +
 rtl/led_serial_sched.sv | 169 ++++++++++++++++
 tb/tb_led_serial_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default timing for the LED job scheduler.
package led_pkg;

    localparam int KEY_W = 128;
    localparam int BLK_W = 64;

    localparam int DEF_START_CYCLES = 2;
    localparam int DEF_TIMEOUT      = 4096;
    localparam int DEF_RST_CYCLES   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        RECOVER,
        RESP
    } sched_state_e;

endpackage

// File: rtl/led_rr_arb2.sv
// Two-input round-robin grant; last_grant is held by the parent.
module led_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        // On contention, favour whichever requester was not served last.
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/led_serial_sched.sv
// Shares one bit-serial LED core between two requesters: arbitrate, start,
// detect completion on done's rising edge, and recover a hung core by timeout.
module led_serial_sched
    import led_pkg::*;
#(
    parameter int START_CYCLES = DEF_START_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int RST_CYCLES   = DEF_RST_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [KEY_W-1:0]   req0_key,
    input  logic [BLK_W-1:0]   req0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [KEY_W-1:0]   req1_key,
    input  logic [BLK_W-1:0]   req1_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BLK_W-1:0]   rsp_data,
    output logic               rsp_id,
    output logic               rsp_err,
    output logic               busy,
    output logic               core_reset,
    output logic               core_start,
    output logic [KEY_W-1:0]   core_keyi,
    output logic [BLK_W-1:0]   core_datai,
    input  logic [BLK_W-1:0]   core_dataq,
    input  logic               core_done
);

    sched_state_e      state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              done_q, done_d;
    logic              recover_q, recover_d;
    logic              core_start_q, core_start_d;
    logic [KEY_W-1:0]  keyi_q, keyi_d;
    logic [BLK_W-1:0]  datai_q, datai_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_id_q, rsp_id_d;
    logic [BLK_W-1:0]  rsp_data_q, rsp_data_d;
    logic [1:0]        grant;
    logic              done_rise;

    led_rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign done_rise  = core_done & ~done_q;
    assign req0_ready = (state_q == IDLE) & grant[0];
    assign req1_ready = (state_q == IDLE) & grant[1];
    assign busy       = (state_q != IDLE);
    assign core_reset = reset | recover_q;
    assign core_start = core_start_q;
    assign core_keyi  = keyi_q;
    assign core_datai = datai_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        done_d       = core_done;
        recover_d    = recover_q;
        core_start_d = core_start_q;
        keyi_d       = keyi_q;
        datai_d      = datai_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    keyi_d       = grant[1] ? req1_key  : req0_key;
                    datai_d      = grant[1] ? req1_data : req0_data;
                    last_grant_d = grant[1];
                    rsp_id_d     = grant[1];
                    core_start_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = START;
                end
            end
            START: begin
                if (cnt_q == 32'(START_CYCLES - 1)) begin
                    core_start_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = RUN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RUN: begin
                // A done level left over from the previous job has no rising edge here.
                if (done_rise) begin
                    rsp_data_d  = core_dataq;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    recover_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = RECOVER;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    recover_d   = 1'b0;
                    cnt_d       = '0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            done_q       <= 1'b0;
            recover_q    <= 1'b0;
            core_start_q <= 1'b0;
            keyi_q       <= '0;
            datai_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
            recover_q    <= recover_d;
            core_start_q <= core_start_d;
            keyi_q       <= keyi_d;
            datai_q      <= datai_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_led_serial_sched.sv
// Randomized bench for led_serial_sched with a stub core (dataq = datai ^ keyi[63:0]).
module tb_led_serial_sched;

    localparam int START = 2;
    localparam int TMO   = 256;
    localparam int RSTC  = 4;

    logic         clk = 0;
    logic         reset = 1;
    logic         req0_valid = 0, req1_valid = 0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_key = '0, req1_key = '0;
    logic [63:0]  req0_data = '0, req1_data = '0;
    logic         rsp_valid, rsp_ready = 0;
    logic [63:0]  rsp_data;
    logic         rsp_id, rsp_err, busy;
    logic         core_reset, core_start;
    logic [127:0] core_keyi;
    logic [63:0]  core_datai;
    logic [63:0]  core_dataq = '0;
    logic         core_done = 0;

    led_serial_sched #(.START_CYCLES(START), .TIMEOUT(TMO), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_data(req1_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .busy(busy), .core_reset(core_reset), .core_start(core_start),
        .core_keyi(core_keyi), .core_datai(core_datai), .core_dataq(core_dataq), .core_done(core_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Stub core knobs
    int stub_delay = 200;
    bit stub_hang  = 0;
    bit stub_stale = 0;
    bit stub_armed = 0;
    int stub_cnt   = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_reset) begin
            core_done  <= 0;
            stub_armed <= 0;
            stub_cnt   <= 0;
        end else if (core_start) begin
            stub_armed <= 1;
            stub_cnt   <= 0;
            if (!stub_stale) core_done <= 0;
        end else if (stub_armed && !stub_hang) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_stale && stub_cnt == 10) core_done <= 0;
            if (stub_cnt == stub_delay - 1) begin
                core_done  <= 1;
                stub_armed <= 0;
                core_dataq <= core_datai ^ core_keyi[63:0];
            end
        end
    end

    // Reference model: one job in flight, alternating grant on contention
    bit           in_flight = 0, seen = 0, last_id = 1, cur_id = 0, exp_err = 0;
    logic [127:0] cur_key;
    logic [63:0]  cur_data, exp_data;
    int           acc_cyc = 0, exp_lat = 0, start_cnt = 0, rst_cnt = 0;
    int           n_done = 0;

    always @(negedge clk) begin
        if (reset) begin
            in_flight = 0;
            seen      = 0;
            last_id   = 1;
        end else begin
            if (in_flight) begin
                if (busy) begin
                    chk("keyi_hold", core_keyi, cur_key);
                    chk("datai_hold", core_datai, cur_data);
                end
                if (core_start) start_cnt++;
                if (core_reset) rst_cnt++;
            end
            if (rsp_valid) begin
                if (!in_flight) chk("spurious_rsp", rsp_valid, 0);
                else begin
                    if (!seen) begin
                        seen = 1;
                        chk("latency", cyc - acc_cyc, exp_lat);
                        chk("start_cycles", start_cnt, START);
                        chk("core_reset_cycles", rst_cnt, exp_err ? RSTC : 0);
                    end
                    chk("rsp_data", rsp_data, exp_err ? 64'd0 : exp_data);
                    chk("rsp_id", rsp_id, cur_id);
                    chk("rsp_err", rsp_err, exp_err);
                    chk("ready_in_resp", {req1_ready, req0_ready}, 0);
                    chk("start_in_resp", core_start, 0);
                    if (rsp_ready) begin
                        in_flight = 0;
                        n_done++;
                    end
                end
            end
            if (req0_ready | req1_ready) begin
                chk("ready_idle", busy, 0);
                chk("ready_onehot", req0_ready & req1_ready, 0);
            end
            if ((req0_valid & req0_ready) | (req1_valid & req1_ready)) begin
                bit id, exp_id;
                id     = req1_valid & req1_ready;
                exp_id = (req0_valid & req1_valid) ? ~last_id : req1_valid;
                chk("accept_while_busy", in_flight, 0);
                chk("grant_id", id, exp_id);
                last_id   = id;
                cur_id    = id;
                in_flight = 1;
                seen      = 0;
                start_cnt = 0;
                rst_cnt   = 0;
                cur_key   = id ? req1_key : req0_key;
                cur_data  = id ? req1_data : req0_data;
                exp_data  = cur_data ^ cur_key[63:0];
                exp_err   = stub_hang;
                exp_lat   = stub_hang ? START + TMO + RSTC : START + stub_delay + 1;
                acc_cyc   = cyc + 1;
            end
        end
    end

    // rsp_ready driver: 0 random, 1 held low, 2 held high
    int rdy_mode = 2;
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 0;
            default: rsp_ready = 1;
        endcase
    end

    bit           fix_en = 0;
    logic [127:0] fix_key;
    logic [63:0]  fix_data;

    task automatic new_job(input int id);
        logic [127:0] k;
        logic [63:0]  d;
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        d = {$urandom(), $urandom()};
        if (fix_en && id == 0) begin
            k = fix_key;
            d = fix_data;
            fix_en = 0;
        end
        if (id == 0) begin req0_key = k; req0_data = d; req0_valid = 1; end
        else         begin req1_key = k; req1_data = d; req1_valid = 1; end
    endtask

    task automatic run_jobs(input int n0, input int n1);
        int r0 = n0, r1 = n1, guard = 0;
        logic a0, a1;
        @(posedge clk); #1;
        if (r0 > 0) new_job(0);
        if (r1 > 0) new_job(1);
        while ((r0 > 0 || r1 > 0 || in_flight) && guard < 5000) begin
            @(negedge clk);
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            @(posedge clk); #1;
            guard++;
            if (a0) begin r0--; if (r0 > 0) new_job(0); else req0_valid = 0; end
            if (a1) begin r1--; if (r1 > 0) new_job(1); else req1_valid = 0; end
        end
        chk("run_bound", guard < 5000, 1);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        #22;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_keyi", core_keyi, 0);
        chk("rst_core_datai", core_datai, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        reset = 0;
        repeat (3) @(posedge clk);

        // Known vector, full-latency path
        fix_en = 1; fix_key = 128'h29cdbaabf2fbe3467cc254f81be8e78d; fix_data = 64'h67c6697351ff4aec;
        stub_delay = 200;
        run_jobs(1, 0);
        chk("vec1_data", core_dataq, 64'h1b043d8b4a17ad61);
        chk("vec1_jobs", n_done, 1);

        // Fairness under contention
        stub_delay = 30;
        run_jobs(2, 2);
        chk("fair_jobs", n_done, 5);

        // Hung core -> recovery, then a normal job
        stub_hang = 1;
        run_jobs(1, 0);
        stub_hang = 0;
        run_jobs(0, 1);
        chk("tmo_jobs", n_done, 7);

        // Response backpressure for 50 cycles with a second job pending
        rdy_mode = 1;
        fork
            run_jobs(2, 0);
            begin
                int g = 0;
                while (!rsp_valid && g < 1000) begin @(posedge clk); #1; g++; end
                chk("stall_wait", g < 1000, 1);
                repeat (50) @(posedge clk);
                #1 rdy_mode = 2;
            end
        join
        chk("stall_jobs", n_done, 9);

        // Stale done level carried into the next jobs
        stub_delay = 40;
        stub_stale = 1;
        run_jobs(1, 1);
        stub_stale = 0;

        // Reset in the middle of RUN: job dropped, no response
        stub_delay = 200;
        @(posedge clk); #1;
        new_job(0);
        begin
            int g = 0;
            while (!busy && g < 20) begin @(posedge clk); #1; g++; end
            chk("mid_accept", busy, 1);
        end
        req0_valid = 0;
        repeat (60) @(posedge clk);
        #2 reset = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_core_reset", core_reset, 1);
        chk("mid_rst_keyi", core_keyi, 0);
        chk("mid_rst_datai", core_datai, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #2 reset = 0;
        repeat (300) @(posedge clk);
        chk("mid_rst_no_rsp", rsp_valid, 0);

        // Golden vector after reset; requester 0 wins first again
        fix_en = 1; fix_key = 128'h66320db73158a35a255d051758e95ed4; fix_data = 64'h765a2e63339fc99a;
        stub_delay = 50;
        run_jobs(1, 1);

        // Random mixes
        for (int i = 0; i < 6; i++) begin
            stub_delay = $urandom_range(12, 150);
            rdy_mode   = $urandom_range(0, 2) == 1 ? 0 : 2;
            run_jobs($urandom_range(0, 2), $urandom_range(1, 2));
        end
        rdy_mode = 2;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
